// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM encoding and index sizing.
package mul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StCalc = 2'd1;
    localparam state_t StFin  = 2'd2;

    // Width of a chunk index counter for n chunks (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_chunk.sv
// Combinational unsigned CHUNK x CHUNK multiplier producing a 2*CHUNK product.
module mul_chunk #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0]   a,
    input  logic [CHUNK-1:0]   b,
    output logic [2*CHUNK-1:0] prod
);

    assign prod = (2*CHUNK)'(a) * (2*CHUNK)'(b);

endmodule

// File: rtl/iter_mul.sv
// Iterative signed/unsigned multiplier: one chunk partial product per cycle,
// full 2*WIDTH product or low-half-only mode, req/ack handshake with abort on re-req.
module iter_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             op_signed,
    input  logic             op_full,
    input  logic [WIDTH-1:0] p0,
    input  logic [WIDTH-1:0] p1,
    output logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = idx_width(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_width
        $error("iter_mul: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t               state;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic                 neg;
    logic                 full;
    logic [IW-1:0]        i_idx;
    logic [IW-1:0]        j_idx;
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH-1:0]     p0_mag;
    logic [WIDTH-1:0]     p1_mag;
    logic [CHUNK-1:0]     a_chunk;
    logic [CHUNK-1:0]     b_chunk;
    logic [2*CHUNK-1:0]   prod;
    logic [31:0]          i_ext;
    logic [31:0]          j_ext;
    logic [31:0]          shamt;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   res;
    logic [IW-1:0]        j_last;
    logic                 last_pair;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        p0_mag = (op_signed && p0[WIDTH-1]) ? -p0 : p0;
        p1_mag = (op_signed && p1[WIDTH-1]) ? -p1 : p1;
    end

    // Chunk selection, shifted accumulation and iteration bookkeeping.
    always_comb begin
        i_ext    = 32'(i_idx);
        j_ext    = 32'(j_idx);
        a_chunk  = a_mag[i_ext*CHUNK +: CHUNK];
        b_chunk  = b_mag[j_ext*CHUNK +: CHUNK];
        shamt    = CHUNK * (i_ext + j_ext);
        acc_next = acc + ((2*WIDTH)'(prod) << shamt);
        // Low mode only visits i+j < N: those terms cover every bit of the low half.
        j_last    = full ? LAST : (LAST - i_idx);
        last_pair = (i_idx == LAST) && (j_idx == j_last);
        res       = neg ? -acc : acc;
    end

    mul_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .prod (prod)
    );

    // Control FSM and datapath registers; a req in any state restarts the operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            a_mag  <= '0;
            b_mag  <= '0;
            neg    <= 1'b0;
            full   <= 1'b0;
            i_idx  <= '0;
            j_idx  <= '0;
            acc    <= '0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            out_lo <= '0;
            out_hi <= '0;
        end else if (req) begin
            state  <= StCalc;
            a_mag  <= p0_mag;
            b_mag  <= p1_mag;
            neg    <= op_signed & (p0[WIDTH-1] ^ p1[WIDTH-1]);
            full   <= op_full;
            i_idx  <= '0;
            j_idx  <= '0;
            acc    <= '0;
            ack    <= 1'b0;
            busy   <= 1'b1;
            out_lo <= '0;
            out_hi <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                StIdle: begin
                    state <= StIdle;
                end
                StCalc: begin
                    acc <= acc_next;
                    if (last_pair) begin
                        state <= StFin;
                    end else if (j_idx == j_last) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                StFin: begin
                    out_lo <= res[WIDTH-1:0];
                    out_hi <= full ? res[2*WIDTH-1:WIDTH] : '0;
                    ack    <= 1'b1;
                    busy   <= 1'b0;
                    i_idx  <= '0;
                    j_idx  <= '0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul.sv
// Self-checking bench for iter_mul at WIDTH=32 and WIDTH=64 against a behavioural model.
module tb_iter_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        op_signed = 1'b0;
    logic        op_full = 1'b0;
    logic [63:0] p0 = '0;
    logic [63:0] p1 = '0;

    logic        ack32, busy32, ack64, busy64;
    logic [31:0] lo32, hi32;
    logic [63:0] lo64, hi64;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    iter_mul #(.WIDTH(32), .CHUNK(16)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_signed (op_signed),
        .op_full   (op_full),
        .p0        (p0[31:0]),
        .p1        (p1[31:0]),
        .ack       (ack32),
        .busy      (busy32),
        .out_lo    (lo32),
        .out_hi    (hi32)
    );

    iter_mul #(.WIDTH(64), .CHUNK(16)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_signed (op_signed),
        .op_full   (op_full),
        .p0        (p0),
        .p1        (p1),
        .ack       (ack64),
        .busy      (busy64),
        .out_lo    (lo64),
        .out_hi    (hi64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product: {hi, lo} of the w-bit operands as plain integer arithmetic.
    function automatic logic [127:0] mul_ref(input int w, input logic s, input logic f,
                                             input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, av, bv, pr, lo, hi;
        mask = (128'd1 << w) - 128'd1;
        av = {64'd0, a} & mask;
        bv = {64'd0, b} & mask;
        if (s && av[w-1]) av = av - (128'd1 << w);
        if (s && bv[w-1]) bv = bv - (128'd1 << w);
        pr = av * bv;
        lo = pr & mask;
        hi = (pr >> w) & mask;
        if (!f) hi = '0;
        return {hi[63:0], lo[63:0]};
    endfunction

    function automatic int n_ops(input int w, input logic f);
        int n;
        n = w / 16;
        return f ? n * n : n * (n + 1) / 2;
    endfunction

    // Behavioural model: ack fires P+1 edges after the latest accept.
    int           m_cnt [2];
    logic         m_ack [2];
    logic         m_busy[2];
    logic [63:0]  m_lo  [2];
    logic [63:0]  m_hi  [2];
    logic [127:0] m_pend[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_cnt[d]  <= 0;
                m_ack[d]  <= 1'b0;
                m_busy[d] <= 1'b0;
                m_lo[d]   <= '0;
                m_hi[d]   <= '0;
                m_pend[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (req) begin
                    m_cnt[d]  <= n_ops(d == 0 ? 32 : 64, op_full) + 1;
                    m_ack[d]  <= 1'b0;
                    m_busy[d] <= 1'b1;
                    m_lo[d]   <= '0;
                    m_hi[d]   <= '0;
                    m_pend[d] <= mul_ref(d == 0 ? 32 : 64, op_signed, op_full, p0, p1);
                end else if (m_cnt[d] == 1) begin
                    m_cnt[d]  <= 0;
                    m_ack[d]  <= 1'b1;
                    m_busy[d] <= 1'b0;
                    m_lo[d]   <= m_pend[d][63:0];
                    m_hi[d]   <= m_pend[d][127:64];
                end else begin
                    if (m_cnt[d] > 1) m_cnt[d] <= m_cnt[d] - 1;
                    m_ack[d] <= 1'b0;
                end
            end
        end
    end

    // Per-cycle compare of both DUTs against the model, plus ack pulse-width check.
    logic prev_ack32 = 1'b0;
    logic prev_ack64 = 1'b0;
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            check("ack32",  {63'd0, ack32},  {63'd0, m_ack[0]});
            check("busy32", {63'd0, busy32}, {63'd0, m_busy[0]});
            check("lo32",   {32'd0, lo32},   m_lo[0]);
            check("hi32",   {32'd0, hi32},   m_hi[0]);
            check("ack64",  {63'd0, ack64},  {63'd0, m_ack[1]});
            check("busy64", {63'd0, busy64}, {63'd0, m_busy[1]});
            check("lo64",   lo64,            m_lo[1]);
            check("hi64",   hi64,            m_hi[1]);
            check("ack32_width", {63'd0, ack32 & prev_ack32}, 64'd0);
            check("ack64_width", {63'd0, ack64 & prev_ack64}, 64'd0);
        end
        prev_ack32 <= ack32;
        prev_ack64 <= ack64;
    end

    // One operation on the 32-bit instance; lat = edges after the accept edge until ack.
    task automatic run_op(input logic s, input logic f, input logic [63:0] a,
                          input logic [63:0] b, output int lat);
        @(negedge clk);
        req = 1'b1; op_signed = s; op_full = f; p0 = a; p1 = b;
        @(negedge clk);
        req = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ack32) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 edges");
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int acks;
        logic [127:0] pin;

        // Pin the reference model itself with hand-computed values.
        pin = mul_ref(32, 1'b0, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        check("model_ufull_hi", pin[127:64], 64'hFFFF_FFFE);
        check("model_ufull_lo", pin[63:0],   64'h0000_0001);
        pin = mul_ref(32, 1'b1, 1'b1, 64'hFFFF_FFFD, 64'd5);
        check("model_sfull_hi", pin[127:64], 64'hFFFF_FFFF);
        check("model_sfull_lo", pin[63:0],   64'hFFFF_FFF1);

        // Reset state.
        #1;
        check("rst_ack",  {63'd0, ack32},  64'd0);
        check("rst_busy", {63'd0, busy32}, 64'd0);
        check("rst_lo",   {32'd0, lo32},   64'd0);
        check("rst_hi",   {32'd0, hi32},   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Idle with req=0: nothing happens.
        repeat (3) @(negedge clk);
        check("idle_ack", {63'd0, ack32}, 64'd0);

        // 1: unsigned full all-ones.
        run_op(1'b0, 1'b1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, lat);
        check("u_full_lat", 64'(lat), 64'd5);
        check("u_full_hi", {32'd0, hi32}, 64'hFFFF_FFFE);
        check("u_full_lo", {32'd0, lo32}, 64'h0000_0001);

        // 2: signed full.
        run_op(1'b1, 1'b1, 64'hFFFF_FFFD, 64'd5, lat);
        check("s_neg_hi", {32'd0, hi32}, 64'hFFFF_FFFF);
        check("s_neg_lo", {32'd0, lo32}, 64'hFFFF_FFF1);
        run_op(1'b1, 1'b1, 64'h8000_0000, 64'h8000_0000, lat);
        check("s_min_hi", {32'd0, hi32}, 64'h4000_0000);
        check("s_min_lo", {32'd0, lo32}, 64'h0);

        // 3: low mode.
        run_op(1'b0, 1'b0, 64'h0001_0000, 64'h0001_0000, lat);
        check("low_lat", 64'(lat), 64'd4);
        check("low_carry_lo", {32'd0, lo32}, 64'h0);
        check("low_carry_hi", {32'd0, hi32}, 64'h0);
        run_op(1'b1, 1'b0, 64'h1234_5678, 64'h9ABC_DEF0, lat);
        check("low_mix_lo", {32'd0, lo32}, 64'h242D_2080);
        check("low_mix_hi", {32'd0, hi32}, 64'h0);

        // 4: abort and restart on edge 2.
        repeat (20) @(negedge clk);
        req = 1'b1; op_signed = 1'b0; op_full = 1'b1; p0 = 64'd7; p1 = 64'd6;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; p0 = 64'd9; p1 = 64'd9;
        @(negedge clk);
        req = 1'b0;
        acks = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (ack32) acks++;
        end
        check("abort_acks", 64'(acks), 64'd1);
        check("abort_lo", {32'd0, lo32}, 64'd81);
        check("abort_hi", {32'd0, hi32}, 64'd0);

        // 5: async reset mid-calculation, then a fresh op.
        repeat (20) @(negedge clk);
        req = 1'b1; op_signed = 1'b0; op_full = 1'b1; p0 = 64'h1234_5678; p1 = 64'h0000_0003;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_busy", {63'd0, busy32}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",  {63'd0, ack32},  64'd0);
        check("mid_rst_busy", {63'd0, busy32}, 64'd0);
        check("mid_rst_lo",   {32'd0, lo32},   64'd0);
        check("mid_rst_hi",   {32'd0, hi32},   64'd0);
        check("mid_rst_busy64", {63'd0, busy64}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b1, 64'h0000_1234, 64'h0000_0010, lat);
        check("post_rst_lat", 64'(lat), 64'd5);
        check("post_rst_lo", {32'd0, lo32}, 64'h0001_2340);
        check("post_rst_hi", {32'd0, hi32}, 64'h0);

        // 6: randomized ops with random spacing (short gaps abort running ops).
        for (int n = 0; n < 4000; n++) begin
            logic [63:0] ra, rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = 64'h8000_0000_8000_0000;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: ra = 64'd0;
                default: ;
            endcase
            @(negedge clk);
            req = 1'b1;
            op_signed = 1'($urandom_range(0, 1));
            op_full = 1'($urandom_range(0, 1));
            p0 = ra;
            p1 = rb;
            @(negedge clk);
            req = 1'b0;
            repeat ($urandom_range(0, 19)) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
